// File: rtl/counter_pkg.sv
// Shared state encoding and tick-rate defaults for the HEX0 counter path.
package counter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Simulation-friendly rates; the board build overrides with the BOARD_ set.
    localparam int SIM_RATE0   = 1;
    localparam int SIM_RATE1   = 5;
    localparam int SIM_RATE2   = 10;
    localparam int SIM_RATE3   = 20;
    localparam int BOARD_RATE0 = 1;
    localparam int BOARD_RATE1 = 50_000_000;
    localparam int BOARD_RATE2 = 100_000_000;
    localparam int BOARD_RATE3 = 200_000_000;

    function automatic logic is_busy(input state_e s);
        return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/rate_tick.sv
// Programmable down-counting divider: emits a tick when it reaches zero while running.
module rate_tick #(
    parameter int DIV_W = 26
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_reload,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_div;

    assign o_tick = i_run && (r_div == '0);

    // Holding (neither load nor run) freezes the divider so a pause resumes mid-period.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div <= '0;
        end else if (i_clear) begin
            r_div <= '0;
        end else if (i_load || o_tick) begin
            r_div <= i_reload;
        end else if (i_run) begin
            r_div <= r_div - DIV_W'(1);
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Run controller for the HEX0 counter: load/run/pause/stop/terminal-count sequencing.
//   state    | meaning
//   IDLE  0  | stopped, count cleared
//   LOAD  1  | one cycle: take load_val, latch up/speed, preset divider
//   RUN   2  | divider running, count steps on each tick
//   PAUSE 3  | divider and count frozen
//   DONE  4  | terminal count reached, count held
module count_sequencer
    import counter_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int DIV_W = 26,
    parameter int RATE0 = SIM_RATE0,
    parameter int RATE1 = SIM_RATE1,
    parameter int RATE2 = SIM_RATE2,
    parameter int RATE3 = SIM_RATE3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_pause,
    input  logic             i_up,
    input  logic [1:0]       i_speed,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_state
);

    localparam logic [DIV_W-1:0] L_RATE0 = DIV_W'(RATE0);
    localparam logic [DIV_W-1:0] L_RATE1 = DIV_W'(RATE1);
    localparam logic [DIV_W-1:0] L_RATE2 = DIV_W'(RATE2);
    localparam logic [DIV_W-1:0] L_RATE3 = DIV_W'(RATE3);

    state_e           r_state, w_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             r_up;
    logic [1:0]       r_speed;
    logic [1:0]       w_speed_sel;
    logic [DIV_W-1:0] w_rate, w_reload;
    logic [CNT_W-1:0] w_terminal;
    logic             w_tick;

    // In LOAD the divider presets from the live speed input; afterwards from the latched copy.
    always_comb begin
        w_speed_sel = (r_state == ST_LOAD) ? i_speed : r_speed;
        case (w_speed_sel)
            2'b00:   w_rate = L_RATE0;
            2'b01:   w_rate = L_RATE1;
            2'b10:   w_rate = L_RATE2;
            default: w_rate = L_RATE3;
        endcase
        w_reload   = w_rate - DIV_W'(1);
        w_terminal = r_up ? '1 : '0;
    end

    rate_tick #(.DIV_W(DIV_W)) u_rate_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (i_stop),
        .i_load   (r_state == ST_LOAD),
        .i_run    (r_state == ST_RUN),
        .i_reload (w_reload),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_next       = r_state;
        w_count_next = r_count;
        if (i_stop) begin
            w_next       = ST_IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) w_next = ST_LOAD;
                ST_LOAD: begin
                    w_count_next = i_load_val;
                    w_next       = ST_RUN;
                end
                ST_RUN: begin
                    if (w_tick && (r_count != w_terminal))
                        w_count_next = r_up ? r_count + CNT_W'(1) : r_count - CNT_W'(1);
                    // Pause outranks the terminal tick; the DONE tick recurs after resume.
                    if (i_pause)
                        w_next = ST_PAUSE;
                    else if (w_tick && (r_count == w_terminal))
                        w_next = ST_DONE;
                end
                ST_PAUSE: if (!i_pause) w_next = ST_RUN;
                ST_DONE:  if (i_start) w_next = ST_LOAD;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_up    <= 1'b0;
            r_speed <= 2'b00;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
            if (r_state == ST_LOAD && !i_stop) begin
                r_up    <= i_up;
                r_speed <= i_speed;
            end
        end
    end

    assign o_count = r_count;
    assign o_tick  = w_tick;
    assign o_busy  = is_busy(r_state);
    assign o_done  = (r_state == ST_DONE);
    assign o_state = r_state;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: vector table plus multi-cycle timing sequences.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, up = 1'b0;
    logic [1:0] speed = 2'b00;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic       tick, busy, done;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    count_sequencer dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_stop     (stop),
        .i_pause    (pause),
        .i_up       (up),
        .i_speed    (speed),
        .i_load_val (load_val),
        .o_count    (count),
        .o_tick     (tick),
        .o_busy     (busy),
        .o_done     (done),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       start, stop, pause, up;
        logic [1:0] speed;
        logic [3:0] lv;
        logic [3:0] e_count;
        logic       e_tick, e_busy, e_done;
        logic [2:0] e_state;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic st, logic sp, logic pa, logic u,
                                logic [1:0] spd, logic [3:0] lv, logic [3:0] ec,
                                logic et, logic eb, logic ed, logic [2:0] es);
        vec_t v;
        v.name = nm; v.start = st; v.stop = sp; v.pause = pa; v.up = u;
        v.speed = spd; v.lv = lv; v.e_count = ec; v.e_tick = et;
        v.e_busy = eb; v.e_done = ed; v.e_state = es;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string name, int ec, int et, int eb, int ed, int es);
        check({name, ".count"}, int'(count), ec);
        check({name, ".tick"},  int'(tick),  et);
        check({name, ".busy"},  int'(busy),  eb);
        check({name, ".done"},  int'(done),  ed);
        check({name, ".state"}, int'(state), es);
    endtask

    // Steps until tick is seen; returns the number of steps taken.
    task automatic wait_tick(input bit toggle_speed, output int n);
        n = 0;
        do begin
            if (toggle_speed) speed = speed + 2'd1;
            step();
            n++;
        end while (!tick && n < 200);
        if (!tick) begin
            n_checks++;
            n_errors++;
            $display("FAIL tick_timeout: got no tick expected tick within 200 cycles");
        end
    endtask

    initial begin
        int  n;
        int  total;
        bit  frozen;
        int  exp_cnt [3] = '{2, 1, 0};

        // reset state
        reset = 1'b1;
        step(); step();
        check_all("reset_init", 0, 0, 0, 0, 0);
        reset = 1'b0;

        vecs.push_back(mk("t2_start",   1,0,0,1,2'd0,4'd12, 4'd0, 0,1,0,3'd1));
        vecs.push_back(mk("t2_cnt12",   0,0,0,1,2'd0,4'd12, 4'd12,1,1,0,3'd2));
        vecs.push_back(mk("t2_cnt13",   0,0,0,1,2'd0,4'd12, 4'd13,1,1,0,3'd2));
        vecs.push_back(mk("t2_cnt14",   0,0,0,1,2'd0,4'd12, 4'd14,1,1,0,3'd2));
        vecs.push_back(mk("t2_cnt15",   0,0,0,1,2'd0,4'd12, 4'd15,1,1,0,3'd2));
        vecs.push_back(mk("t2_done",    0,0,0,1,2'd0,4'd12, 4'd15,0,0,1,3'd4));
        vecs.push_back(mk("t2_hold",    0,0,0,1,2'd0,4'd12, 4'd15,0,0,1,3'd4));
        vecs.push_back(mk("stop_wins",  1,1,0,1,2'd0,4'd12, 4'd0, 0,0,0,3'd0));
        vecs.push_back(mk("idle_hold",  0,0,0,0,2'd0,4'd0,  4'd0, 0,0,0,3'd0));
        vecs.push_back(mk("start_lv5",  1,0,0,0,2'd0,4'd5,  4'd0, 0,1,0,3'd1));
        vecs.push_back(mk("stop_load",  0,1,0,0,2'd0,4'd5,  4'd0, 0,0,0,3'd0));
        vecs.push_back(mk("restart",    1,0,0,0,2'd0,4'd5,  4'd0, 0,1,0,3'd1));
        vecs.push_back(mk("load_cnt5",  0,0,0,0,2'd0,4'd5,  4'd5, 1,1,0,3'd2));
        vecs.push_back(mk("midrun_chg", 0,0,0,1,2'd3,4'd9,  4'd4, 1,1,0,3'd2));
        vecs.push_back(mk("start_busy", 1,0,0,1,2'd3,4'd9,  4'd3, 1,1,0,3'd2));
        vecs.push_back(mk("pause_in",   0,0,1,1,2'd3,4'd9,  4'd2, 0,1,0,3'd3));
        vecs.push_back(mk("pause_hold", 0,0,1,1,2'd3,4'd9,  4'd2, 0,1,0,3'd3));
        vecs.push_back(mk("resume",     0,0,0,1,2'd3,4'd9,  4'd2, 1,1,0,3'd2));
        vecs.push_back(mk("dn_cnt1",    0,0,0,1,2'd3,4'd9,  4'd1, 1,1,0,3'd2));
        vecs.push_back(mk("dn_cnt0",    0,0,0,1,2'd3,4'd9,  4'd0, 1,1,0,3'd2));
        vecs.push_back(mk("dn_done",    0,0,0,1,2'd3,4'd9,  4'd0, 0,0,1,3'd4));

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; pause = vecs[i].pause;
            up = vecs[i].up; speed = vecs[i].speed; load_val = vecs[i].lv;
            step();
            check_all(vecs[i].name, int'(vecs[i].e_count), int'(vecs[i].e_tick),
                      int'(vecs[i].e_busy), int'(vecs[i].e_done), int'(vecs[i].e_state));
        end
        start = 0; stop = 0; pause = 0;

        // count down from 3 at RATE 5
        load_val = 4'd3; up = 1'b0; speed = 2'b01; start = 1'b1;
        step();
        check("t3_load", int'(state), 1);
        start = 1'b0;
        step();
        check("t3_run_cnt", int'(count), 3);
        wait_tick(1'b0, n);
        check("t3_first_tick", n, 4);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_cnt", int'(count), exp_cnt[k]);
            wait_tick(1'b0, n);
            check("t3_spacing", n + 1, 5);
        end
        step();
        check("t3_done_state", int'(state), 4);
        check("t3_done_flag", int'(done), 1);

        // pause during RATE 10 run stretches tick spacing to 17
        load_val = 4'd0; up = 1'b1; speed = 2'b10; start = 1'b1;
        step();
        start = 1'b0;
        step();
        wait_tick(1'b0, n);
        check("t4_first_tick", n, 9);
        for (int k = 0; k < 4; k++) step();
        check("t4_cnt_before", int'(count), 1);
        pause = 1'b1;
        frozen = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            if (count != 4'd1 || tick || state != 3'd3) frozen = 1'b0;
        end
        check("t4_frozen", int'(frozen), 1);
        pause = 1'b0;
        wait_tick(1'b0, n);
        total = 4 + 7 + n;
        check("t4_spacing", total, 17);
        check("t4_cnt_at_tick", int'(count), 1);

        // stop from PAUSE with count 9; start in the same cycle loses
        stop = 1'b1;
        step();
        check("t5_stop_run", int'(state), 0);
        stop = 1'b0;
        load_val = 4'd9; up = 1'b1; speed = 2'b01; start = 1'b1;
        step();
        start = 1'b0; pause = 1'b1;
        step();
        check("t5_run_no_pause_in_load", int'(state), 2);
        step();
        check("t5_paused", int'(state), 3);
        check("t5_cnt9", int'(count), 9);
        stop = 1'b1; start = 1'b1;
        step();
        check_all("t5_stop", 0, 0, 0, 0, 0);
        stop = 1'b0; start = 1'b0; pause = 1'b0;
        step();
        check("t5_still_idle", int'(state), 0);

        // restart from DONE at speed 11; speed toggling mid-run ignored
        load_val = 4'd15; up = 1'b1; speed = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("t6_done", int'(state), 4);
        load_val = 4'd0; speed = 2'b11; start = 1'b1;
        step();
        check("t6_load", int'(state), 1);
        start = 1'b0;
        step();
        check("t6_run", int'(state), 2);
        wait_tick(1'b1, n);
        check("t6_first_tick", n, 19);
        step();
        check("t6_cnt1", int'(count), 1);
        wait_tick(1'b1, n);
        check("t6_period20", n + 1, 20);

        // reset mid-RUN
        step(); step(); step();
        reset = 1'b1;
        step(); step();
        check_all("t1_reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        check("t1_after_reset", int'(state), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
